clb_config_loader: RTL
======================

// Module: clb_config_loader
// PURPOSE
//  Serial configuration loader feeding config_fpga sel1..sel4 (CLB slice/carry-chain routing).
//  Hunts a serial bitstream for a sync word, then shifts in an 8-bit routing payload plus even
//  parity. Validates the payload and commits it atomically to the held sel outputs.
//  Bad frames never reach the fabric; the last good configuration stays live.
// PARAMETERS
//  SYNC_WORD  8'hA5  frame sync pattern, MSB first
//  TIMEOUT    64     max idle cycles between accepted bits in LOAD before abort
// PORTS
//  clk        in   1  clock; all state changes on rising edge
//  rst        in   1  synchronous, active-high reset
//  cfg_valid  in   1  cfg_bit valid this cycle
//  cfg_bit    in   1  serial config data bit
//  cfg_ready  out  1  loader accepts a bit this cycle
//  busy       out  1  high in LOAD or CHECK
//  sel1..sel4 out  2  each; routing selects to config_fpga (held registers)
//  cfg_done   out  1  one-cycle pulse on a successful commit
//  cfg_error  out  1  sticky error flag
//  err_code   out  2  01 parity, 10 not-permutation, 11 timeout, 00 none
// BEHAVIOUR
//  Reset: state=HUNT; sync shreg=0; bit_cnt=0; timer=0.
//   sel1=00, sel2=01, sel3=10, sel4=11 (identity straight chain).
//   cfg_done=0, cfg_error=0, err_code=00, busy=0.
//  Accept: a bit is taken on an edge where cfg_valid && cfg_ready.
//   cfg_ready=1 in HUNT/LOAD, 0 in CHECK. cfg_bit is ignored when not accepted.
//  Frame: SYNC_WORD, then payload p[7:0] MSB first, then parity bit P.
//   sel4=p[7:6], sel3=p[5:4], sel2=p[3:2], sel1=p[1:0].
//   Parity is even: ^{p,P} must equal 0.
//  HUNT: each accepted bit shifts into the 8-bit sync shreg (LSB in).
//   If {shreg[6:0],bit}==SYNC_WORD -> LOAD; bit_cnt=0, timer=0.
//   Sliding match: any bit alignment is found; shreg is cleared on every entry to HUNT.
//  LOAD: accepted bits shift into the shadow register; bit_cnt increments.
//   On the 9th bit (P) -> CHECK.
//   timer counts cycles with no accepted bit; it resets to 0 on each accepted bit.
//   When timer reaches TIMEOUT-1 with no accept: cfg_error=1, err_code=11, -> HUNT; sels unchanged.
//  CHECK (exactly 1 cycle), priority order:
//   1) parity fail -> cfg_error=1, err_code=01.
//   2) sel values not a permutation of {0,1,2,3} -> cfg_error=1, err_code=10.
//   3) otherwise commit all four sels on the same edge; cfg_error=0; err_code=00;
//      cfg_done=1 for the following cycle only.
//   Always -> HUNT afterwards.
//  Latency: P accepted on edge N -> CHECK during cycle N..N+1 -> sels and cfg_done update at edge N+1.
//  Sels only change at reset or at a passing CHECK; never partially.
//  cfg_error is sticky until the next successful commit or reset.
//  rst mid-LOAD/CHECK: frame discarded; all registers return to reset values on that edge.
//  A sync pattern appearing inside a payload is treated as payload, not resync.
// TESTING
//  1 Reset, then idle 5 cycles -> sel1..4=00/01/10/11, cfg_done=0, cfg_error=0, busy=0, cfg_ready=1.
//  2 Send A5, payload 8'h1B, P=0 -> sel1=11, sel2=10, sel3=01, sel4=00.
//    cfg_done high exactly 1 cycle at edge after P; err_code=00.
//  3 Send A5, payload 8'h1B, P=1 -> cfg_error=1, err_code=01, sels unchanged, no cfg_done.
//  4 Send A5, payload 8'h00, P=0 -> err_code=10, sels unchanged.
//    Then send a valid frame 8'hE4, P=0 -> sels 00/01/10/11, cfg_error cleared.
//  5 Send A5 plus 3 payload bits, then hold cfg_valid=0 for 64 cycles -> err_code=11, state HUNT.
//    A following valid frame commits.
//  6 Send noise bits 1,0,1,1 then A5 + valid frame, with cfg_valid toggling randomly -> commits correctly.
//    Repeat with rst pulsed after 4 payload bits -> identity sels, no cfg_done.

Source files
------------

// File: rtl/clb_config_loader.sv
// Serial configuration loader: finds a sync word in the bitstream, shifts in an 8-bit routing
// payload plus even parity, and commits the four 2-bit routing selects only if the frame checks.
//   state    | meaning
//   ST_HUNT  | sliding search for SYNC_WORD in the accepted bit stream
//   ST_LOAD  | shifting payload + parity into the shadow register, idle timer running
//   ST_CHECK | one cycle: validate shadow, commit or flag error, back to hunt
module clb_config_loader #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cfg_valid,
  input  logic       i_cfg_bit,
  output logic       o_cfg_ready,
  output logic       o_busy,
  output logic [1:0] o_sel1,
  output logic [1:0] o_sel2,
  output logic [1:0] o_sel3,
  output logic [1:0] o_sel4,
  output logic       o_cfg_done,
  output logic       o_cfg_error,
  output logic [1:0] o_err_code
);

  localparam int unsigned   TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_sync;
  logic [8:0]    r_shadow;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_sel;
  logic          r_cfg_done;
  logic          r_cfg_error;
  logic [1:0]    r_err_code;

  logic       w_accept;
  logic [7:0] w_sync_next;
  logic       w_sync_hit;
  logic       w_last_bit;
  logic       w_timeout;
  logic       w_parity_ok;
  logic [3:0] w_seen;
  logic       w_perm_ok;

  assign o_cfg_ready = (r_state != ST_CHECK);
  assign o_busy      = (r_state != ST_HUNT);
  assign {o_sel4, o_sel3, o_sel2, o_sel1} = r_sel;
  assign o_cfg_done  = r_cfg_done;
  assign o_cfg_error = r_cfg_error;
  assign o_err_code  = r_err_code;

  assign w_accept    = i_cfg_valid & o_cfg_ready;
  assign w_sync_next = {r_sync[6:0], i_cfg_bit};
  assign w_sync_hit  = (r_state == ST_HUNT) && w_accept && (w_sync_next == SYNC_WORD);
  assign w_last_bit  = (r_state == ST_LOAD) && w_accept && (r_bit_cnt == 4'd8);
  assign w_timeout   = (r_state == ST_LOAD) && !w_accept && (r_timer == TIMER_LAST);
  assign w_parity_ok = ~(^r_shadow);

  // Payload sits in r_shadow[8:1]; the four fields form a permutation iff every value is seen.
  always_comb begin
    w_seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_seen[r_shadow[2*i+1 +: 2]] = 1'b1;
    end
  end
  assign w_perm_ok = &w_seen;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_sync_hit) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_last_bit)     w_state_nxt = ST_CHECK;
        else if (w_timeout) w_state_nxt = ST_HUNT;
      end
      ST_CHECK: w_state_nxt = ST_HUNT;
      default:  w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 8'h00;
      r_shadow    <= 9'h000;
      r_bit_cnt   <= 4'd0;
      r_timer     <= '0;
      r_sel       <= 8'hE4;
      r_cfg_done  <= 1'b0;
      r_cfg_error <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_accept) r_sync <= w_sync_next;
          if (w_sync_hit) begin
            r_bit_cnt <= 4'd0;
            r_timer   <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_shadow  <= {r_shadow[7:0], i_cfg_bit};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_timer   <= '0;
          end else if (w_timeout) begin
            r_cfg_error <= 1'b1;
            r_err_code  <= 2'b11;
            r_sync      <= 8'h00;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CHECK: begin
          r_sync <= 8'h00;
          if (!w_parity_ok) begin
            r_cfg_error <= 1'b1;
            r_err_code  <= 2'b01;
          end else if (!w_perm_ok) begin
            r_cfg_error <= 1'b1;
            r_err_code  <= 2'b10;
          end else begin
            r_sel       <= r_shadow[8:1];
            r_cfg_error <= 1'b0;
            r_err_code  <= 2'b00;
            r_cfg_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
